// File: rtl/serial_adder_sequencer.sv
//==============================================================================
// serial_adder_sequencer: feeds two WIDTH-bit operands to an external 2-bit
// slice adder one pair per clock, LSB first, and assembles sum and carry-out.
// Optional macro: SERIAL_ADDER_OVERFLOW_EN adds a registered o_overflow port.
// Revision: 1.0
//==============================================================================
`default_nettype none

module serial_adder_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_opA,
   input  logic [WIDTH-1:0] i_opB,
   input  logic             i_carry,
`ifdef SERIAL_ADDER_OVERFLOW_EN
   output logic             o_overflow,
`endif
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry,
   output logic             o_bitA0,
   output logic             o_bitA1,
   output logic             o_bitB0,
   output logic             o_bitB1,
   output logic             o_slice_carry,
   input  logic             i_sum0,
   input  logic             i_sum1,
   input  logic             i_slice_carry
);

   localparam int N  = WIDTH / 2;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry_reg;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] next_sum;
   logic             last_pair;

   // New pair enters at the top so the LSB pair ends up in bits [1:0] after N shifts.
   generate
      if (WIDTH == 2) begin : g_sum_narrow
         assign next_sum = {i_sum1, i_sum0};
      end else begin : g_sum_wide
         assign next_sum = {i_sum1, i_sum0, o_sum[WIDTH-1:2]};
      end
   endgenerate

   assign last_pair = (count == CW'(N - 1));

`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic a_msb;
   logic b_msb;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         carry_reg <= 1'b0;
         count     <= '0;
         o_sum     <= '0;
         o_carry   <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         o_overflow <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  a_sh      <= i_opA;
                  b_sh      <= i_opB;
                  carry_reg <= i_carry;
                  count     <= '0;
                  o_sum     <= '0;
                  o_carry   <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                  a_msb      <= i_opA[WIDTH-1];
                  b_msb      <= i_opB[WIDTH-1];
                  o_overflow <= 1'b0;
`endif
                  state     <= RUN;
               end
            end
            RUN: begin
               o_sum     <= next_sum;
               a_sh      <= a_sh >> 2;
               b_sh      <= b_sh >> 2;
               carry_reg <= i_slice_carry;
               count     <= count + CW'(1);
               if (last_pair) begin
                  o_carry <= i_slice_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                  // i_sum1 becomes the sum MSB on this final edge.
                  o_overflow <= (a_msb == b_msb) && (i_sum1 != a_msb);
`endif
                  state   <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign o_busy        = (state != IDLE);
   assign o_done        = (state == DONE);
   assign o_bitA0       = (state == RUN) & a_sh[0];
   assign o_bitA1       = (state == RUN) & a_sh[1];
   assign o_bitB0       = (state == RUN) & b_sh[0];
   assign o_bitB1       = (state == RUN) & b_sh[1];
   assign o_slice_carry = (state == RUN) & carry_reg;

endmodule

`default_nettype wire

// File: doc/serial_adder_sequencer.md
Name: serial_adder_sequencer

Overview:
- Upstream sequencing stage for the 2-bit slice adder (A0,A1,B0,B1,carry in -> sum0,sum1,carry out).
- Accepts two WIDTH-bit operands and a carry-in, then feeds them to the slice adder 2 bits per clock, LSB pair first.
- Registers the slice carry between cycles and assembles the WIDTH-bit sum and final carry.
- Signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand/sum width in bits; must be even and >= 2; slice count N = WIDTH/2.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_start  input  1  request; sampled only in IDLE.
- i_opA  input  WIDTH  operand A, captured on accepted start.
- i_opB  input  WIDTH  operand B, captured on accepted start.
- i_carry  input  1  carry-in, captured on accepted start.
- o_busy  output  1  high in RUN and DONE.
- o_done  output  1  one-cycle pulse; o_sum/o_carry are valid.
- o_sum  output  WIDTH  result register.
- o_carry  output  1  final carry-out.
- o_bitA0, o_bitA1  output  1 each  to slice adder: current A pair, bit0/bit1.
- o_bitB0, o_bitB1  output  1 each  to slice adder: current B pair, bit0/bit1.
- o_slice_carry  output  1  to slice adder: carry into current pair.
- i_sum0, i_sum1  input  1 each  from slice adder: pair sum.
- i_slice_carry  input  1  from slice adder: pair carry-out.

Behaviour:
- Reset (async, i_rst=1): state=IDLE; o_busy=0, o_done=0, o_sum=0, o_carry=0; all slice-drive outputs 0; internal A/B shift registers, carry register and count cleared.
- Reset mid-RUN aborts the operation immediately. No done pulse is issued and the partial sum is discarded (o_sum=0).
- IDLE:
  - On i_start=1: capture i_opA, i_opB into shift regs; carry_reg=i_carry; count=0; o_sum=0; o_carry=0; go to RUN.
  - Otherwise hold. Slice outputs are 0 in IDLE.
- RUN:
  - Slice outputs are combinational from the registers: o_bitA0/A1 = A[0]/A[1], o_bitB0/B1 = B[0]/B[1], o_slice_carry = carry_reg.
  - Each clock:
    - o_sum <= {i_sum1, i_sum0, o_sum[WIDTH-1:2]}
    - A <= A>>2, B <= B>>2 (zero fill)
    - carry_reg <= i_slice_carry
    - count++
  - When count==N-1 on that edge, also o_carry <= i_slice_carry and go to DONE.
  - RUN lasts exactly N cycles.
- DONE (one cycle): o_done=1; slice outputs 0; next state IDLE.
- Latency: start accepted at edge k -> o_done high during cycle k+N+1 -> back in IDLE at k+N+2.
- o_sum/o_carry hold their values after DONE until the next accepted start clears them.
- i_start during RUN or DONE is ignored and not queued. Operand inputs are don't-care except at the accept edge.
- WIDTH=2: RUN is one cycle.
- Arithmetic: {o_carry,o_sum} = i_opA + i_opB + i_carry, computed modulo 2^(WIDTH+1).
- The slice adder is external and purely combinational. This block adds no combinational path from i_sum*/i_slice_carry to any output.

Optional Feature:
- Macro SERIAL_ADDER_OVERFLOW_EN.
- When defined: adds port o_overflow (output, 1 bit), registered.
  - Reset value 0; cleared on accepted start.
  - On the final RUN edge: o_overflow <= (A_msb == B_msb) && (new sum MSB != A_msb), i.e. two's-complement signed overflow.
  - A_msb and B_msb are latched copies of the operand MSBs taken at the accept edge.
  - Holds with o_sum.
- When undefined: port and logic are absent; the block is otherwise identical.

Test Plan:
- Basic add (WIDTH=8, bench models the slice adder): opA=0x5A, opB=0x33, carry=0, start -> o_sum=0x8D, o_carry=0. Exactly 4 RUN cycles; o_done is a one-cycle pulse. Check slice pairs in order: (A 10, B 11), (10, 00), (01, 11), (01, 00).
- Carry chain: opA=0xFF, opB=0x01, carry=0 -> o_sum=0x00, o_carry=1. Repeat with opA=0xFF, opB=0xFF, carry=1 -> o_sum=0xFF, o_carry=1.
- Start while busy: pulse start with 0x01+0x01 during RUN of 0x10+0x20 -> result 0x30, o_carry=0. Only one done pulse; the ignored request is never executed.
- Reset mid-operation: assert i_rst asynchronously in the 2nd RUN cycle -> all outputs 0 immediately, no o_done. A new start of 0x0F+0x01 after release -> 0x10.
- Back-to-back: start held high continuously -> a new operation is accepted every N+2 cycles. o_busy drops for exactly one IDLE cycle between operations.
- Overflow (SERIAL_ADDER_OVERFLOW_EN defined):
  - 0x7F+0x01 -> o_sum=0x80, o_overflow=1.
  - 0x80+0xFF -> o_sum=0x7F, o_carry=1, o_overflow=1.
  - 0x10+0x20 -> o_overflow=0.
